// File: rtl/wb_irqc_pkg.sv
// Shared constants and helpers for the Wishbone interrupt controller.
// Register offsets use adr[3:2]; CLAIM encodes {valid, index}.
package wb_irqc_pkg;

    localparam logic [1:0] IRQC_REG_PENDING = 2'd0;
    localparam logic [1:0] IRQC_REG_ENABLE  = 2'd1;
    localparam logic [1:0] IRQC_REG_MODE    = 2'd2;
    localparam logic [1:0] IRQC_REG_CLAIM   = 2'd3;

    localparam int CLAIM_VALID_BIT = 31;

    // Lowest set index wins; returns {valid, index[4:0]}, all zero when vec==0.
    function automatic logic [5:0] prio_enc(input logic [31:0] vec);
        logic [5:0] res;
        res = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, 5'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_irqc_if.sv
// Classic Wishbone slave bus bundle; dat_i is master-to-slave write data.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_i, input dat_o, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_i, output dat_o, ack);
endinterface

// File: rtl/wb_irqc_line.sv
// One interrupt line: edge detector plus PENDING bit with level/edge handling.
// In edge mode a rise event beats a simultaneous W1C.
module irqc_line (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic mode,
    input  logic w1c,
    output logic pending
);
    logic irq_q;
    logic pend_q;
    logic pend_d;
    logic rise_s;

    // Next PENDING value: level mode tracks the line, edge mode latches rises.
    always_comb begin
        rise_s = irq & ~irq_q;
        if (mode) begin
            if (rise_s) begin
                pend_d = 1'b1;
            end else if (w1c) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
        end else begin
            pend_d = irq;
        end
    end

    // Line history and PENDING state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_q  <= irq;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
endmodule

// File: rtl/wb_irqc.sv
// Wishbone interrupt controller: PENDING/ENABLE/MODE/CLAIM registers and a
// registered CPU interrupt request; one-cycle ack per sampled request.
module wb_irqc
    import wb_irqc_pkg::*;
#(
    parameter int          N_IRQ        = 16,
    parameter logic [31:0] RESET_ENABLE = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wishbone_if.slave        wb,
    input  logic [N_IRQ-1:0] irq_i,
    output logic             irq_o
);
    localparam logic [31:0] LINE_MASK = (N_IRQ >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << N_IRQ) - 32'd1);

    logic             ack_q;
    logic [31:0]      dat_q, dat_d;
    logic             irq_o_q;
    logic [31:0]      enable_q, enable_d;
    logic [31:0]      mode_q, mode_d;
    logic             req_s, wr_s, rd_s;
    logic [31:0]      wmask_s, w1c_s, rdata_s, pend_ext_s, active_s;
    logic [5:0]       claim_s;
    logic [N_IRQ-1:0] pend_s;
    logic             unused_s;

    assign req_s   = wb.cyc & wb.stb & ~ack_q;
    assign wr_s    = req_s & wb.we;
    assign rd_s    = req_s & ~wb.we;
    assign wmask_s = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}} & LINE_MASK;

    generate
        if (N_IRQ < 32) begin : g_ext
            assign pend_ext_s = {{(32-N_IRQ){1'b0}}, pend_s};
        end else begin : g_full
            assign pend_ext_s = pend_s;
        end
    endgenerate

    assign active_s = pend_ext_s & enable_q;
    assign claim_s  = prio_enc(active_s);
    assign unused_s = ^{wb.adr[31:4], wb.adr[1:0], w1c_s};

    // Register writes, W1C strobes and read-data selection.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c_s    = 32'd0;
        rdata_s  = 32'd0;
        dat_d    = dat_q;
        if (wr_s) begin
            case (wb.adr[3:2])
                IRQC_REG_PENDING: w1c_s    = wb.dat_i & wmask_s & mode_q;
                IRQC_REG_ENABLE:  enable_d = (enable_q & ~wmask_s) | (wb.dat_i & wmask_s);
                IRQC_REG_MODE:    mode_d   = (mode_q & ~wmask_s) | (wb.dat_i & wmask_s);
                default:          w1c_s    = 32'd0;
            endcase
        end else begin
            w1c_s = 32'd0;
        end
        case (wb.adr[3:2])
            IRQC_REG_PENDING: rdata_s = pend_ext_s;
            IRQC_REG_ENABLE:  rdata_s = enable_q;
            IRQC_REG_MODE:    rdata_s = mode_q;
            IRQC_REG_CLAIM:   rdata_s = {claim_s[5], 26'd0, claim_s[4:0]};
            default:          rdata_s = 32'd0;
        endcase
        if (rd_s) begin
            dat_d = rdata_s;
        end else begin
            dat_d = dat_q;
        end
    end

    // Bus handshake, control registers and the CPU request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            irq_o_q  <= 1'b0;
            enable_q <= RESET_ENABLE & LINE_MASK;
            mode_q   <= 32'd0;
        end else begin
            ack_q    <= req_s;
            dat_q    <= dat_d;
            irq_o_q  <= |active_s;
            enable_q <= enable_d;
            mode_q   <= mode_d;
        end
    end

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irqc_line u_line (
            .clk     (clk_i),
            .rst     (rst_i),
            .irq     (irq_i[i]),
            .mode    (mode_q[i]),
            .w1c     (w1c_s[i]),
            .pending (pend_s[i])
        );
    end

    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_q;
    assign irq_o    = irq_o_q;
endmodule

// File: tb/tb_wb_irqc.sv
// Scoreboard bench for wb_irqc: reads push expected data, a negedge monitor
// pops and compares on every read ack.
module tb_wb_irqc;
    localparam int N = 16;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_i;
    logic         irq_o;
    wishbone_if   wb();

    exp_t sb_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   ack_cnt = 0;
    int   issued = 0;

    wb_irqc #(.N_IRQ(N), .RESET_ENABLE(32'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb.slave),
        .irq_i (irq_i),
        .irq_o (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count every ack and compare read data against the scoreboard.
    always @(negedge clk) begin
        if (!rst && wb.ack) begin
            ack_cnt++;
            if (!wb.we) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_read_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(e.name, wb.dat_o, e.data);
                end
            end
        end
    end

    task automatic wb_req(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit set_irq, input logic [N-1:0] irq_val);
        int lat;
        lat = 99;
        @(negedge clk);
        wb.we    = we;
        wb.adr   = {28'h1234567, adr};
        wb.dat_i = dat;
        wb.sel   = sel;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        if (set_irq) irq_i = irq_val;
        issued++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (wb.ack) begin
                lat = c;
                break;
            end
        end
        check("ack_latency", 32'(lat), 32'd0);
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_req(1'b1, adr, dat, sel, 1'b0, '0);
    endtask

    task automatic rd(input string name, input logic [3:0] adr, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.data = exp;
        sb_q.push_back(e);
        wb_req(1'b0, adr, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        irq_i = '0;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.sel = 4'h0; wb.adr = 32'h0; wb.dat_i = 32'h0;
        tick(3);
        check("rst_ack", 32'(wb.ack), 32'd0);
        check("rst_dat", wb.dat_o, 32'd0);
        rst = 1'b0;
        tick(1);
        check("rst_irq_o", 32'(irq_o), 32'd0);
        rd("rst_pending", 4'h0, 32'h0);
        rd("rst_enable", 4'h4, 32'h0);
        rd("rst_mode", 4'h8, 32'h0);
        rd("rst_claim", 4'hC, 32'h0);

        // Level mode on line 2.
        wr(4'h4, 32'h0000_0004, 4'hF);
        irq_i = 16'h0004;
        tick(1);
        check("lvl_irq_o_1cyc", 32'(irq_o), 32'd0);
        tick(1);
        check("lvl_irq_o_2cyc", 32'(irq_o), 32'd1);
        rd("lvl_pending", 4'h0, 32'h0000_0004);
        rd("lvl_claim", 4'hC, 32'h8000_0002);
        irq_i = 16'h0000;
        tick(1);
        check("lvl_drop_1cyc", 32'(irq_o), 32'd1);
        tick(1);
        check("lvl_drop_2cyc", 32'(irq_o), 32'd0);
        rd("lvl_pending_clr", 4'h0, 32'h0);

        // Edge mode with W1C on line 0.
        wr(4'h8, 32'h0000_0001, 4'hF);
        wr(4'h4, 32'h0000_0001, 4'hF);
        irq_i = 16'h0001;
        tick(1);
        irq_i = 16'h0000;
        tick(3);
        check("edge_irq_o", 32'(irq_o), 32'd1);
        rd("edge_pending", 4'h0, 32'h0000_0001);
        wr(4'h0, 32'h0000_0001, 4'hF);
        tick(2);
        check("w1c_irq_o", 32'(irq_o), 32'd0);
        rd("w1c_pending", 4'h0, 32'h0);

        // Rise event coincides with W1C: set wins.
        irq_i = 16'h0001;
        tick(1);
        irq_i = 16'h0000;
        tick(2);
        wb_req(1'b1, 4'h0, 32'h0000_0001, 4'hF, 1'b1, 16'h0001);
        irq_i = 16'h0000;
        rd("set_wins", 4'h0, 32'h0000_0001);
        wr(4'h0, 32'h0000_0001, 4'hF);
        rd("set_wins_clr", 4'h0, 32'h0);

        // Priority between edge lines 3 and 7.
        wr(4'h8, 32'h0000_0088, 4'hF);
        wr(4'h4, 32'h0000_0088, 4'hF);
        rd("prio_mode", 4'h8, 32'h0000_0088);
        irq_i = 16'h0088;
        tick(1);
        irq_i = 16'h0000;
        tick(2);
        check("prio_irq_o", 32'(irq_o), 32'd1);
        rd("prio_claim3", 4'hC, 32'h8000_0003);
        wr(4'h0, 32'h0000_0008, 4'hF);
        rd("prio_claim7", 4'hC, 32'h8000_0007);
        wr(4'h4, 32'h0000_0000, 4'hF);
        rd("prio_claim_none", 4'hC, 32'h0);
        tick(2);
        check("prio_irq_o_off", 32'(irq_o), 32'd0);
        rd("prio_pending", 4'h0, 32'h0000_0080);
        wr(4'hC, 32'hFFFF_FFFF, 4'hF);
        rd("claim_ro", 4'hC, 32'h0);

        // Byte enables and masking of bits above N_IRQ.
        wr(4'h4, 32'h0000_FFFF, 4'b0010);
        rd("sel_byte1", 4'h4, 32'h0000_FF00);
        wr(4'h4, 32'h0000_0000, 4'b0000);
        rd("sel_none", 4'h4, 32'h0000_FF00);
        wr(4'h4, 32'hFFFF_FFFF, 4'hF);
        rd("enable_mask", 4'h4, 32'h0000_FFFF);
        tick(2);
        check("pend7_irq_o", 32'(irq_o), 32'd1);

        // Asynchronous reset while a request is being acked.
        @(negedge clk);
        wb.we = 1'b0; wb.adr = 32'h4; wb.sel = 4'hF;
        wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_ack", 32'(wb.ack), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_ack", 32'(wb.ack), 32'd0);
        check("async_rst_irq_o", 32'(irq_o), 32'd0);
        check("async_rst_dat", wb.dat_o, 32'd0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        tick(2);
        rst = 1'b0;
        rd("post_rst_pending", 4'h0, 32'h0);
        rd("post_rst_enable", 4'h4, 32'h0);
        rd("post_rst_mode", 4'h8, 32'h0);
        rd("post_rst_claim", 4'hC, 32'h0);

        for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick(1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("ack_count", 32'(ack_cnt), 32'(issued));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/wb_irqc.md
Name: wb_irqc

Overview:
- Wishbone-slave interrupt controller that consumes the 16-bit simulation-control IRQ bus (and any other peripheral IRQ lines) and presents one interrupt request to the CPU.
- Per-line enable, per-line edge/level mode, a pending register and a claim register returning the highest-priority pending line.
- Synthesizable. Sits between the IRQ sources and the CPU interrupt input, on the same Wishbone bus as other peripherals.

Parameters:
- N_IRQ, 16, number of interrupt lines (1..32); line 0 has highest priority.
- RESET_ENABLE, 32'h0, reset value of the ENABLE register (bits above N_IRQ ignored).

Ports:
- wb.clk_i  in  1  clock; all logic on rising edge.
- wb.rst_i  in  1  reset, asynchronous, active-high.
- wb  slave (wishbone_if.slave)  -  carries cyc, stb, we, sel[3:0], adr[31:0], dat_i[31:0], dat_o[31:0], ack.
- irq_i  in  N_IRQ  raw interrupt lines, synchronous to wb.clk_i.
- irq_o  out  1  interrupt request to CPU, registered.

Behaviour:
- Reset (async assert, sync-released use): ack=0, dat_o=0, irq_o=0, PENDING=0, MODE=0 (all level), ENABLE=RESET_ENABLE, irq_q=0. Reset mid-transaction drops ack immediately; the access is lost and the master must retry.
- Register map (adr[3:2]; adr[31:4] ignored; bits >= N_IRQ read 0, writes ignored):
  - 0x0 PENDING: R. W1C for edge-mode lines; writes to level-mode bits ignored.
  - 0x4 ENABLE: RW.
  - 0x8 MODE: RW, 1=rising edge, 0=level-high.
  - 0xC CLAIM: RO. bit31=valid; [4:0]=index of lowest-numbered line with PENDING&ENABLE; reads 0 when none. Writes ignored, still acked.
- Handshake: ack=1 for exactly one cycle, the cycle after cyc&stb is sampled with ack=0. Back-to-back requests therefore take 2 cycles each. dat_o valid in the ack cycle and holds its value otherwise. Requests with cyc=0 or stb=0 are never acked.
- Writes honour sel per byte; sel=0 is acked with no effect.
- Register update happens at the same edge ack rises.
- Edge detect: irq_q <= irq_i every cycle. Rise event = irq_i & ~irq_q.
- PENDING update, per line:
  - Level mode: PENDING[i] = irq_i[i] registered, one cycle latency.
  - Edge mode: set on a rise event; cleared by W1C.
  - A rise event in the same cycle as a W1C of that bit: set wins.
- MODE change level->edge: PENDING bit keeps its current value until cleared. MODE change edge->level: PENDING follows the line from the next cycle.
- irq_o <= |(PENDING & ENABLE). Latency from an irq_i edge to irq_o is 2 cycles (PENDING register, then irq_o register).
- ENABLE gates irq_o and CLAIM only. Disabled lines still latch PENDING.
- CLAIM is combinational from the current PENDING&ENABLE and registered into dat_o on read. Priority is a fixed lowest-index-first encoder.

Decomposition:
- wb_irqc_pkg:
  - localparams IRQC_REG_PENDING=2'd0, IRQC_REG_ENABLE=2'd1, IRQC_REG_MODE=2'd2, IRQC_REG_CLAIM=2'd3.
  - CLAIM_VALID_BIT=31.
  - Function prio_enc(logic [31:0]) returning {valid, index[4:0]}.
- Sub-module irqc_line: one per line via generate. Holds irq_q, the PENDING bit and mode/W1C/set-priority logic. Ports: clk, rst, irq, mode, w1c, pending.

Test Plan:
- Reset with ENABLE=RESET_ENABLE=0: read all 4 regs -> 0,0,0,0. irq_o=0. Each read acked exactly one cycle after stb.
- Level: write ENABLE=0x0004. Hold irq_i[2]=1 -> PENDING=0x0004, irq_o=1 two cycles later, CLAIM=0x80000002. Drop irq_i[2] -> PENDING=0, irq_o=0 two cycles later.
- Edge + W1C: MODE=0x0001, ENABLE=0x0001. Pulse irq_i[0] one cycle -> PENDING=0x0001 persists, irq_o=1. Write PENDING=0x0001 -> PENDING=0, irq_o=0.
- W1C vs new edge same cycle on line 0 -> PENDING[0] stays 1.
- Priority: edge mode on lines 3,7 with both pending and ENABLE=0x0088 -> CLAIM=0x80000003. Clear line 3 -> CLAIM=0x80000007. ENABLE=0 -> CLAIM=0, irq_o=0, PENDING=0x0080.
- Byte sel: write ENABLE=0xFFFF with sel=4'b0010 -> ENABLE=0xFF00. Assert wb.rst_i asynchronously while stb is high -> ack=0 and all regs at reset values within the same cycle.
